// File: rtl/ad9228_serial_tx.sv
// AD9228 single-channel serial output emulator: parallel samples in over
// valid/ready, DDR din/dco/fco out, MSB first, one clk per half bit.
//
// Ports:
//   clk, rstn          - fabric clock (2x bit rate), sync active-low reset
//   enable             - start/stop serial output (frames never truncated)
//   test_mode          - send internal ramp (AD9228_TX_TESTPAT_EN builds only)
//   s_data/s_valid/s_ready - sample handshake, ready only on IDLE/load cycles
//   din, dco, fco      - registered serial data, bit clock, frame clock
//   underflow          - pulse on a load cycle that repeats the last word
//   frames_sent        - completed-frame counter, wraps at 16 bits
//
// Optional feature macro: AD9228_TX_TESTPAT_EN (internal ramp generator).
// DATA_WIDTH must be even and >= 4.

module ad9228_serial_tx #(
    parameter int DATA_WIDTH   = 12,
    parameter bit DIN_INVERTED = 1'b0,
    parameter bit DCO_INVERTED = 1'b0,
    parameter bit FCO_INVERTED = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  test_mode,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  din,
    output logic                  dco,
    output logic                  fco,
    output logic                  underflow,
    output logic [15:0]           frames_sent
);

    localparam int FRAME = 2 * DATA_WIDTH;
    localparam int CW    = $clog2(FRAME);

    localparam logic [CW-1:0] C_LAST = CW'(FRAME - 1);
    localparam logic [CW-1:0] C_HALF = CW'(DATA_WIDTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [15:0]           frames_q, frames_d;
    logic                  din_q, dco_q, fco_q;
    logic                  din_d, dco_d, fco_d;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  load;
    logic                  tp;

`ifdef AD9228_TX_TESTPAT_EN
    logic [DATA_WIDTH-1:0] ramp_q, ramp_d;
    assign tp = test_mode;
`else
    // Without the ramp generator test_mode has no effect.
    assign tp = test_mode & 1'b0;
`endif

    assign load = (state_q == RUN) && (cnt_q == C_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        frames_d  = frames_q;
        s_ready   = 1'b0;
        underflow = 1'b0;
`ifdef AD9228_TX_TESTPAT_EN
        ramp_d    = ramp_q;
`endif
        if (state_q == IDLE) begin
            s_ready = rstn && enable && !tp;
            cnt_d   = '0;
            if (enable && tp) begin
                state_d = RUN;
                word_d  = '0;
`ifdef AD9228_TX_TESTPAT_EN
                ramp_d  = DATA_WIDTH'(1);
`endif
            end else if (s_valid && s_ready) begin
                state_d = RUN;
                word_d  = s_data;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
            if (load) begin
                cnt_d    = '0;
                frames_d = frames_q + 16'd1;
                if (!enable) begin
                    state_d = IDLE;
                end else if (tp) begin
`ifdef AD9228_TX_TESTPAT_EN
                    word_d = ramp_q;
                    ramp_d = ramp_q + DATA_WIDTH'(1);
`endif
                end else begin
                    s_ready = rstn;
                    if (s_valid) begin
                        word_d = s_data;
                    end else begin
                        // No new sample: the shift word is simply reused.
                        underflow = rstn;
                    end
                end
            end
        end
    end

    // Outputs are derived from next state so the registered pins line
    // up with the frame position the block is entering.
    always_comb begin
        shifted = word_d << cnt_d[CW-1:1];
        din_d   = 1'b0;
        dco_d   = 1'b0;
        fco_d   = 1'b0;
        if (state_d == RUN) begin
            din_d = shifted[DATA_WIDTH-1];
            dco_d = cnt_d[1] ^ cnt_d[0];
            fco_d = cnt_d < C_HALF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            frames_q <= '0;
            din_q    <= DIN_INVERTED;
            dco_q    <= DCO_INVERTED;
            fco_q    <= FCO_INVERTED;
`ifdef AD9228_TX_TESTPAT_EN
            ramp_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            frames_q <= frames_d;
            din_q    <= din_d ^ DIN_INVERTED;
            dco_q    <= dco_d ^ DCO_INVERTED;
            fco_q    <= fco_d ^ FCO_INVERTED;
`ifdef AD9228_TX_TESTPAT_EN
            ramp_q   <= ramp_d;
`endif
        end
    end

    assign din         = din_q;
    assign dco         = dco_q;
    assign fco         = fco_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_ad9228_serial_tx.sv
// Self-checking bench for ad9228_serial_tx: table-driven first frame plus
// hand-written back-to-back, underflow, reset-abort and enable-drop cases.

module tb_ad9228_serial_tx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        test_mode = 1'b0;
    logic        s_valid = 1'b0;
    logic [11:0] s_data = '0;
    logic        s_ready, din, dco, fco, underflow;
    logic [15:0] frames_sent;
    logic        s_ready_n, din_n, dco_n, fco_n, underflow_n;
    logic [15:0] frames_sent_n;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ad9228_serial_tx #(
        .DATA_WIDTH(12)
    ) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .test_mode(test_mode),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .din(din), .dco(dco), .fco(fco), .underflow(underflow),
        .frames_sent(frames_sent)
    );

    ad9228_serial_tx #(
        .DATA_WIDTH(12), .DIN_INVERTED(1'b1),
        .DCO_INVERTED(1'b1), .FCO_INVERTED(1'b1)
    ) dut_inv (
        .clk(clk), .rstn(rstn), .enable(enable), .test_mode(test_mode),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_n),
        .din(din_n), .dco(dco_n), .fco(fco_n), .underflow(underflow_n),
        .frames_sent(frames_sent_n)
    );

    typedef struct {
        logic        en;
        logic        vld;
        logic [11:0] d;
        logic        din;
        logic        dco;
        logic        fco;
        logic        rdy;
        logic        uf;
    } vec_t;

    vec_t tv[26];
    logic ref_bits[12] = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0};

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic edin,
                           input logic edco, input logic efco);
        chk1({nm, " din"}, din, edin);
        chk1({nm, " dco"}, dco, edco);
        chk1({nm, " fco"}, fco, efco);
        chk1({nm, " din_inv"}, din_n, ~edin);
        chk1({nm, " dco_inv"}, dco_n, ~edco);
        chk1({nm, " fco_inv"}, fco_n, ~efco);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk_out(nm, 1'b0, 1'b0, 1'b0);
        chk1({nm, " rdy"}, s_ready, 1'b0);
        chk1({nm, " uf"}, underflow, 1'b0);
        chk16({nm, " frames"}, frames_sent, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        enable = 1'b0;
        s_valid = 1'b0;
        test_mode = 1'b0;
        @(negedge clk);
        #1;
        chk_reset_vals("reset");
        rstn = 1'b1;
    endtask

    task automatic start(input logic [11:0] w);
        @(negedge clk);
        enable = 1'b1;
        s_valid = 1'b1;
        s_data = w;
        #1;
        chk1("start rdy", s_ready, 1'b1);
        chk_out("start", 1'b0, 1'b0, 1'b0);
    endtask

    // Checks one 24-cycle frame carrying w; enable drops at cycle en_drop
    // (24 = stays high), vld/nxt are offered throughout the frame.
    task automatic frame(input logic [11:0] w, input int en_drop,
                         input logic vld, input logic [11:0] nxt);
        logic [11:0] des = '0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            enable = (c < en_drop);
            s_valid = vld;
            s_data = nxt;
            #1;
            chk_out("frame", w[11 - c / 2], (c % 4 == 1) || (c % 4 == 2),
                    c < 12);
            chk1("frame rdy", s_ready, (c == 23) && (en_drop > 23));
            chk1("frame uf", underflow,
                 (c == 23) && (en_drop > 23) && !vld);
            if (c % 2 == 0) des = {des[10:0], din};
        end
        chk16("deser", {4'h0, des}, {4'h0, w});
    endtask

    task automatic idle(input int n, input logic e);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enable = e;
            s_valid = !e;
            #1;
            chk_out("idle", 1'b0, 1'b0, 1'b0);
            chk1("idle rdy", s_ready, e);
            chk1("idle uf", underflow, 1'b0);
        end
    endtask

    initial begin
        logic [11:0] des;

        tv[0] = '{1'b1, 1'b1, 12'hA5C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 24; c++) begin
            tv[c + 1] = '{c < 23, 1'b0, 12'h000, ref_bits[c / 2],
                          (c % 4 == 1) || (c % 4 == 2), c < 12,
                          1'b0, 1'b0};
        end
        tv[25] = '{1'b0, 1'b1, 12'h555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // First frame 0xA5C, enable released on the load cycle.
        do_reset();
        des = '0;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            enable = tv[i].en;
            s_valid = tv[i].vld;
            s_data = tv[i].d;
            #1;
            chk_out("tv", tv[i].din, tv[i].dco, tv[i].fco);
            chk1("tv rdy", s_ready, tv[i].rdy);
            chk1("tv uf", underflow, tv[i].uf);
            if (i >= 1 && i <= 24 && (i - 1) % 2 == 0)
                des = {des[10:0], din};
        end
        chk16("tv deser", {4'h0, des}, 16'h0A5C);
        chk16("tv frames", frames_sent, 16'd1);

        // Back-to-back frames; last load sees enable low with valid high.
        do_reset();
        start(12'h001);
        frame(12'h001, 24, 1'b1, 12'hFFE);
        frame(12'hFFE, 24, 1'b1, 12'h800);
        frame(12'h800, 23, 1'b1, 12'h3AA);
        idle(3, 1'b0);
        chk16("b2b frames", frames_sent, 16'd3);

        // Underflow repeats the last word once, then idle with enable high.
        do_reset();
        start(12'h123);
        frame(12'h123, 24, 1'b0, 12'h000);
        frame(12'h123, 23, 1'b0, 12'h000);
        idle(2, 1'b1);
        chk16("uf frames", frames_sent, 16'd2);

        // Reset at c=10 aborts the frame.
        start(12'hABC);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        @(negedge clk);
        rstn = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        #1;
        chk_reset_vals("abort");
        rstn = 1'b1;

        // Enable dropped at c=5: frame still completes, then idle.
        start(12'h3C6);
        frame(12'h3C6, 5, 1'b1, 12'h777);
        idle(3, 1'b0);
        chk16("drop frames", frames_sent, 16'd1);

`ifdef AD9228_TX_TESTPAT_EN
        do_reset();
        @(negedge clk);
        test_mode = 1'b1;
        enable = 1'b1;
        s_valid = 1'b1;
        #1;
        chk1("ramp idle rdy", s_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            des = '0;
            for (int c = 0; c < 24; c++) begin
                @(negedge clk);
                enable = !(k == 2 && c == 23);
                #1;
                chk1("ramp rdy", s_ready, 1'b0);
                chk1("ramp uf", underflow, 1'b0);
                if (c % 2 == 0) des = {des[10:0], din};
            end
            chk16("ramp word", {4'h0, des}, 16'(k));
        end
        test_mode = 1'b0;
        idle(2, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ad9228_serial_tx.md
# ad9228_serial_tx

- Emulates the serial output of one AD9228 channel: takes parallel samples over a valid/ready handshake and drives `din`, `dco` and `fco` in the AD9228 DDR format.
- Format: MSB first, two bits per DCO period, FCO high for the first half of each frame.
- Sits in the board-test path. Its outputs feed the channel deserializer for loopback and bring-up without a physical ADC.
- Runs entirely in one fabric clock at twice the bit rate, so DCO edges land mid-bit.

## Interface
Parameters:
- `DATA_WIDTH`, 12, sample width; must be even and ≥ 4.
- `DIN_INVERTED`, 0, invert `din` at the output register.
- `DCO_INVERTED`, 0, invert `dco` at the output register.
- `FCO_INVERTED`, 0, invert `fco` at the output register.

Ports (clock and reset first):
- `clk` input 1: single clock; one clock cycle is half a bit period.
- `rstn` input 1: active-low reset, synchronous to `clk`.
- `enable` input 1: start/stop serial output.
- `test_mode` input 1: select the internal ramp; only meaningful with `AD9228_TX_TESTPAT_EN`.
- `s_data` input DATA_WIDTH: sample to transmit.
- `s_valid` input 1: `s_data` is valid.
- `s_ready` output 1: the block accepts a sample this cycle.
- `din` output 1: serial data.
- `dco` output 1: bit clock.
- `fco` output 1: frame clock.
- `underflow` output 1: one-cycle pulse when a frame repeats the previous word.
- `frames_sent` output 16: count of completed frames; wraps.

## Operation
- Frame position counter `c` runs 0..2·DATA_WIDTH−1. Bit index is `b = c>>1`; bit `b` occupies cycles 2b and 2b+1.
- `din` = shift word bit [DATA_WIDTH−1−b] (MSB first).
- `dco` = 1 when `c mod 4` ∈ {1,2}, else 0. Rising edge is mid-bit of even bits; falling edge is mid-bit of odd bits.
- `fco` = 1 for c < DATA_WIDTH, 0 otherwise.
- All three outputs are registered, then XORed with the corresponding `*_INVERTED` parameter.
- States:
  - IDLE: outputs at logical 0; `c` = 0. `s_ready` = `enable` && !test-pattern-active. A transfer (`s_valid && s_ready`) loads the word and moves to RUN with c=0 next cycle. With `enable` high and no valid, the block stays in IDLE and does not flag underflow.
  - RUN: `c` increments each cycle. At c = 2·DATA_WIDTH−1 (load cycle):
    - `s_ready` = 1.
    - On a transfer, the next frame sends `s_data`.
    - With no transfer, the next frame repeats the last word and `underflow` pulses that cycle.
    - `frames_sent` increments.
    - If `enable` is 0 on the load cycle, the block goes to IDLE and does not accept a word (`s_ready` = 0).
  - `enable` falling mid-frame: the current frame always completes; no truncated frames.
- `s_ready` is 0 on every cycle other than those listed above.
- The last-word register resets to 0.

## Timing
- Latency: a word accepted on the edge ending cycle X drives its MSB on `din` in cycle X+1, with `fco`=1 and `dco`=0.
- Frame length is 2·DATA_WIDTH cycles (24 for 12-bit). DCO period is 4 cycles. Throughput is one word per frame, back-to-back with no gap.
- Reset values (`rstn`=0 at an edge):
  - State IDLE, `c` = 0, last word 0.
  - `din` = DIN_INVERTED, `dco` = DCO_INVERTED, `fco` = FCO_INVERTED.
  - `s_ready` = 0, `underflow` = 0, `frames_sent` = 0.
- Reset mid-frame aborts the frame immediately; the next cycle shows the reset values.
- Simultaneous `enable` fall and `s_valid` on the load cycle: the word is not accepted; the block goes to IDLE.
- `frames_sent` wraps 0xFFFF → 0x0000.

## Configuration
- `AD9228_TX_TESTPAT_EN` defined:
  - When `test_mode`=1, each frame sends an internal ramp instead of `s_data`, and `s_ready` is held 0.
  - Ramp starts at 0 on entry from IDLE, increments by 1 per frame, and wraps 2^DATA_WIDTH−1 → 0.
  - In test mode, RUN is entered from IDLE when `enable`=1, without needing `s_valid`; `underflow` never pulses.
  - `test_mode` is sampled only in IDLE and on load cycles.
- `AD9228_TX_TESTPAT_EN` not defined: `test_mode` is ignored and no ramp logic is built.

## Test plan
- Reset then `enable`=1, one word 0xA5C accepted (12-bit):
  - 24-cycle frame; `din` bits 1,0,1,0,0,1,0,1,1,1,0,0, each held 2 cycles.
  - `fco` high cycles 0–11; `dco` pattern 0,1,1,0 repeating.
  - Loopback deserializer output = 0xA5C.
- Back-to-back words 0x001, 0xFFE, 0x800 with `s_valid` always high:
  - No gap between frames; `s_ready` high only on each load cycle.
  - `frames_sent` = 3 after 72 cycles.
- `s_valid` dropped after 0x123:
  - Next frame repeats 0x123; `underflow` pulses exactly once on that load cycle.
- `enable` cleared at c=5:
  - Frame completes through c=23, then IDLE; outputs 0; no word accepted.
- `rstn` low at c=10:
  - Next cycle all outputs at their reset values; `frames_sent` = 0.
- With `DIN_INVERTED`=1, and separately with `AD9228_TX_TESTPAT_EN` and `test_mode`=1:
  - Inverted case: `din` is the complement of the reference waveform.
  - Ramp case: frames carry 0,1,2,… and wrap 0xFFF → 0x000 after 4096 frames.
